// File: rtl/simd_ins_sequencer.sv
// Batch instruction sequencer: PS loads a FIFO, pulses start, words are issued one at a time.
// Optional SIMD_SEQ_TIMEOUT_EN aborts a batch when ins_done never arrives.
module simd_ins_sequencer #(
    parameter int DEPTH   = 8,
    parameter int INS_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ps_ins_wr,
    input  logic [INS_W-1:0]         ps_ins_data,
    output logic                     ps_full,
    input  logic                     ps_start,
    output logic                     ps_busy,
    output logic                     ps_done,
    output logic                     ps_err,
    output logic [$clog2(DEPTH):0]   ps_count,
    output logic [INS_W-1:0]         ins,
    output logic                     ins_valid,
    input  logic                     ins_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t           state_q;
    logic [INS_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, empty, push;
    logic             busy_q, done_q, valid_q;
    logic [AW:0]      count_q;
    logic [INS_W-1:0] ins_q;

`ifdef SIMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          tmo_hit;

    // A done arriving on the final wait cycle takes priority over the abort.
    assign tmo_hit = (state_q == WAIT) && !ins_done && (tmo_q == TMO_LAST);
    assign ps_err  = err_q;
`else
    wire unused_timeout = ^TIMEOUT;
    assign ps_err = 1'b0;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = ps_ins_wr && !full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q;
        if (state_q == ISSUE)
            rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef SIMD_SEQ_TIMEOUT_EN
        // Flush discards everything, including a word pushed on the abort cycle.
        if (tmo_hit)
            rd_ptr_d = wr_ptr_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= ps_ins_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            ins_q    <= '0;
`ifdef SIMD_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ps_start) begin
                        done_q  <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
`ifdef SIMD_SEQ_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (!empty) begin
                            state_q <= ISSUE;
                            ins_q   <= mem_q[rd_ptr_q[AW-1:0]];
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef SIMD_SEQ_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                WAIT: begin
                    if (ins_done) begin
                        if (count_q != '1)
                            count_q <= count_q + 1'b1;
                        if (!empty) begin
                            state_q <= ISSUE;
                            ins_q   <= mem_q[rd_ptr_q[AW-1:0]];
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= FIN;
                        end
                    end
`ifdef SIMD_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ps_full   = full_q;
    assign ps_busy   = busy_q;
    assign ps_done   = done_q;
    assign ps_count  = count_q;
    assign ins       = ins_q;
    assign ins_valid = valid_q;

endmodule
